// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-approach signal controller: latched demand, gap-out/max-out
// green termination, skipping of idle approaches and an all-red clearance.
module traffic_phase_ctrl #(
   parameter int NUM_DIR   = 4,
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int CNT_W     = 8,
   localparam int DIR_W    = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_DIR-1:0]   car_present,
   output logic [2*NUM_DIR-1:0] lights,
   output logic [DIR_W-1:0]     green_dir,
   output logic                 phase_start,
   output logic [NUM_DIR-1:0]   demand
);

   typedef enum logic [1:0] {
      S_GREEN   = 2'd0,
      S_YELLOW  = 2'd1,
      S_ALL_RED = 2'd2
   } state_t;

   localparam logic [1:0] LAMP_RED    = 2'd0;
   localparam logic [1:0] LAMP_GREEN  = 2'd1;
   localparam logic [1:0] LAMP_YELLOW = 2'd2;

   localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DIR_W-1:0]   green_dir_q, green_dir_d;
   logic [DIR_W-1:0]   next_dir_q, next_dir_d;
   logic [NUM_DIR-1:0] demand_q, demand_d;
   logic               phase_start_q, phase_start_d;

   logic               other_dem;
   logic [DIR_W-1:0]   scan_dir;
   logic               gap_out, max_out;
   logic               dir_bad, state_bad, recover;
   logic [1:0]         lamp_code;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_GREEN;
         cnt_q         <= '0;
         green_dir_q   <= '0;
         next_dir_q    <= '0;
         demand_q      <= '0;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         green_dir_q   <= green_dir_d;
         next_dir_q    <= next_dir_d;
         demand_q      <= demand_d;
         phase_start_q <= phase_start_d;
      end
   end

   // Non-power-of-two NUM_DIR leaves unused green_dir codes; treat them as corruption.
   always_comb begin
      dir_bad = 1'b1;
      for (int j = 0; j < NUM_DIR; j++) begin
         if (green_dir_q == DIR_W'(j)) dir_bad = 1'b0;
      end
   end

   assign state_bad = !(state_q inside {S_GREEN, S_YELLOW, S_ALL_RED});
   assign recover   = dir_bad || state_bad;

   // The approach being served never accumulates demand while it is green.
   always_comb begin
      demand_d = demand_q | car_present;
      for (int j = 0; j < NUM_DIR; j++) begin
         if (state_q == S_GREEN && green_dir_q == DIR_W'(j)) demand_d[j] = 1'b0;
      end
      if (recover) demand_d = '0;
   end

   always_comb begin
      other_dem = 1'b0;
      for (int j = 0; j < NUM_DIR; j++) begin
         if (demand_q[j] && green_dir_q != DIR_W'(j)) other_dem = 1'b1;
      end
   end

   // Descending offset so the nearest demanding approach after green_dir wins.
   always_comb begin
      scan_dir = green_dir_q;
      for (int k = NUM_DIR - 1; k >= 1; k--) begin
         for (int j = 0; j < NUM_DIR; j++) begin
            if (demand_q[j] && ((int'(green_dir_q) + k) % NUM_DIR) == j)
               scan_dir = DIR_W'(j);
         end
      end
   end

   assign gap_out = other_dem && (cnt_q >= GMIN_LAST) && !car_present[green_dir_q];
   assign max_out = other_dem && (cnt_q == GMAX_LAST);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      green_dir_d   = green_dir_q;
      next_dir_d    = next_dir_q;
      phase_start_d = 1'b0;
      case (state_q)
         S_GREEN: begin
            if (gap_out || max_out) begin
               state_d    = S_YELLOW;
               next_dir_d = scan_dir;
            end
         end
         S_YELLOW: begin
            if (cnt_q == YEL_LAST) state_d = S_ALL_RED;
         end
         S_ALL_RED: begin
            if (cnt_q == AR_LAST) begin
               state_d       = S_GREEN;
               green_dir_d   = next_dir_q;
               phase_start_d = 1'b1;
            end
         end
         default: begin
            state_d     = S_GREEN;
            green_dir_d = '0;
            next_dir_d  = '0;
         end
      endcase

      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q == S_GREEN && cnt_q == GMAX_LAST)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + CNT_W'(1);

      if (recover) begin
         state_d       = S_GREEN;
         cnt_d         = '0;
         green_dir_d   = '0;
         next_dir_d    = '0;
         phase_start_d = 1'b0;
      end
   end

   always_comb begin
      lamp_code = LAMP_RED;
      case (state_q)
         S_GREEN:  lamp_code = LAMP_GREEN;
         S_YELLOW: lamp_code = LAMP_YELLOW;
         default:  lamp_code = LAMP_RED;
      endcase
   end

   genvar gi;
   for (gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
      assign lights[2*gi +: 2] = (green_dir_q == DIR_W'(gi)) ? lamp_code : LAMP_RED;
   end

   assign green_dir   = green_dir_q;
   assign phase_start = phase_start_q;
   assign demand      = demand_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: the stimulus pushes hand-computed
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_traffic_phase_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] car_present;
   logic [7:0] lights;
   logic [1:0] green_dir;
   logic       phase_start;
   logic [3:0] demand;

   typedef struct packed {
      int         tid;
      logic [7:0] l;
      logic [1:0] d;
      logic       ps;
      logic [3:0] dem;
      logic [3:0] dm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cur_tid = 0;

   traffic_phase_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .car_present (car_present),
      .lights      (lights),
      .green_dir   (green_dir),
      .phase_start (phase_start),
      .demand      (demand)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_vec++;
         if (lights !== mon_e.l || green_dir !== mon_e.d || phase_start !== mon_e.ps ||
             ((demand ^ mon_e.dem) & mon_e.dm) !== 4'b0000) begin
            n_bad++;
            $display("FAIL t%0d vec %0d: lights=%h need %h, dir=%0d need %0d, ps=%b need %b, demand=%b need %b (mask %b)",
                     mon_e.tid, n_vec, lights, mon_e.l, green_dir, mon_e.d, phase_start, mon_e.ps,
                     demand, mon_e.dem, mon_e.dm);
         end else begin
            $display("t%0d vec %0d: lights=%h dir=%0d ps=%b demand=%b ok",
                     mon_e.tid, n_vec, lights, green_dir, phase_start, demand);
         end
      end
   end

   // Expectation for the outputs visible after the coming edge; then drive next inputs.
   task automatic cyc(input logic rn, input logic [3:0] cn, input logic [7:0] l,
                      input logic [1:0] d, input logic ps, input logic [3:0] dem,
                      input logic [3:0] dm);
      @(posedge clk);
      #1;
      exp_q.push_back('{cur_tid, l, d, ps, dem, dm});
      reset       = rn;
      car_present = cn;
   endtask

   task automatic rep(input int n, input logic [3:0] cn, input logic [7:0] l,
                      input logic [1:0] d, input logic [3:0] dem);
      for (int i = 0; i < n; i++) cyc(1'b0, cn, l, d, 1'b0, dem, 4'hF);
   endtask

   task automatic do_reset(input logic [3:0] car_after);
      @(posedge clk);
      #1;
      reset       = 1'b1;
      car_present = 4'b0000;
      cyc(1'b0, car_after, 8'h01, 2'd0, 1'b0, 4'b0000, 4'hF);
   endtask

   initial begin
      reset       = 1'b1;
      car_present = 4'b0000;

      // 1: idle, approach 0 holds green
      cur_tid = 1;
      do_reset(4'b0000);
      rep(50, 4'b0000, 8'h01, 2'd0, 4'b0000);

      // 2: single car on approach 2, gap-out, approach 1 skipped
      cur_tid = 2;
      do_reset(4'b0100);
      rep(3, 4'b0000, 8'h01, 2'd0, 4'b0100);
      rep(3, 4'b0000, 8'h02, 2'd0, 4'b0100);
      rep(2, 4'b0000, 8'h00, 2'd0, 4'b0100);
      cyc(1'b0, 4'b1000, 8'h10, 2'd2, 1'b1, 4'b0000, 4'b1011);

      // 4: from approach 3 with demand on 0 and 1, scan wraps to 0
      cur_tid = 4;
      rep(3, 4'b0000, 8'h10, 2'd2, 4'b1000);
      rep(3, 4'b0000, 8'h20, 2'd2, 4'b1000);
      rep(2, 4'b0000, 8'h00, 2'd2, 4'b1000);
      cyc(1'b0, 4'b0011, 8'h40, 2'd3, 1'b1, 4'b0000, 4'b0111);
      rep(3, 4'b0000, 8'h40, 2'd3, 4'b0011);
      rep(3, 4'b0000, 8'h80, 2'd3, 4'b0011);
      rep(2, 4'b0000, 8'h00, 2'd3, 4'b0011);
      cyc(1'b0, 4'b0000, 8'h01, 2'd0, 1'b1, 4'b0010, 4'b1110);
      rep(2, 4'b0000, 8'h01, 2'd0, 4'b0010);

      // 3: cars held on 0 and 1, both greens max out at 10 cycles
      cur_tid = 3;
      do_reset(4'b0011);
      rep(9, 4'b0011, 8'h01, 2'd0, 4'b0010);
      rep(1, 4'b0011, 8'h02, 2'd0, 4'b0010);
      rep(2, 4'b0011, 8'h02, 2'd0, 4'b0011);
      rep(2, 4'b0011, 8'h00, 2'd0, 4'b0011);
      cyc(1'b0, 4'b0011, 8'h04, 2'd1, 1'b1, 4'b0001, 4'b1101);
      rep(9, 4'b0011, 8'h04, 2'd1, 4'b0001);
      rep(1, 4'b0011, 8'h08, 2'd1, 4'b0001);
      rep(2, 4'b0011, 8'h08, 2'd1, 4'b0011);
      rep(2, 4'b0011, 8'h00, 2'd1, 4'b0011);
      cyc(1'b0, 4'b0000, 8'h01, 2'd0, 1'b1, 4'b0010, 4'b1110);

      // 5: reset during the second yellow cycle, car present at the reset edge
      cur_tid = 5;
      do_reset(4'b0100);
      rep(3, 4'b0000, 8'h01, 2'd0, 4'b0100);
      rep(1, 4'b0000, 8'h02, 2'd0, 4'b0100);
      cyc(1'b1, 4'b0100, 8'h02, 2'd0, 1'b0, 4'b0100, 4'hF);
      cyc(1'b0, 4'b0000, 8'h01, 2'd0, 1'b0, 4'b0000, 4'hF);
      rep(5, 4'b0000, 8'h01, 2'd0, 4'b0000);

      // 6: only the green approach has cars; nothing ever changes
      cur_tid = 6;
      do_reset(4'b0001);
      rep(40, 4'b0001, 8'h01, 2'd0, 4'b0000);
      car_present = 4'b0000;

      for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised N-approach traffic-light phase controller. It replaces the fixed two-road highway/farm-road scheme with round-robin service over NUM_DIR approaches. Timers are integrated, so external timeout signals are not needed. It adds latched vehicle demand, gap-out and max-out termination of green, skipping of approaches with no demand, and an all-red clearance interval.

Parameters:
NUM_DIR, 4, number of approaches (>=2)
GREEN_MIN, 4, minimum green length in cycles (>=1)
GREEN_MAX, 10, maximum green length in cycles when demand is waiting elsewhere (>=GREEN_MIN)
YELLOW_T, 3, yellow length in cycles (>=1)
ALLRED_T, 2, all-red clearance length in cycles (>=1)
CNT_W, 8, phase timer width; must hold max(GREEN_MAX, YELLOW_T, ALLRED_T)-1
DIR_W, derived localparam, max(1, clog2(NUM_DIR))

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
car_present  in  NUM_DIR  per-approach vehicle detector, level
lights  out  2*NUM_DIR  per-approach lamp code; bits [2i+1:2i] = approach i; RED=0, GREEN=1, YELLOW=2 (3 never driven)
green_dir  out  DIR_W  approach currently owning GREEN/YELLOW
phase_start  out  1  one-cycle pulse on the first GREEN cycle of a new approach
demand  out  NUM_DIR  latched demand vector (observability)

Behaviour:
- Moore FSM with states GREEN, YELLOW, ALL_RED. All outputs are registers or decoded from registers; there are no combinational input-to-output paths.
- Phase counter cnt:
  - cleared on every state change;
  - increments each cycle in YELLOW/ALL_RED;
  - in GREEN, increments and saturates at GREEN_MAX-1.
- Reset (sync, applies in any state, including mid-YELLOW/ALL_RED):
  - state=GREEN, green_dir=0, cnt=0, demand=0, phase_start=0;
  - lights = approach 0 GREEN, all others RED.
- Demand latch, per approach i, each cycle:
  - demand[i] is set when car_present[i]=1;
  - demand[green_dir] is forced to 0 while state=GREEN, and clearing wins over setting;
  - in YELLOW/ALL_RED, demand[green_dir] may be set again.
- other_dem = OR of demand[i] for i != green_dir, using registered demand. A car pulse therefore affects the FSM one cycle later.
- GREEN exit, evaluated each cycle; either condition moves the FSM to YELLOW on the next edge:
  - gap-out: other_dem && cnt>=GREEN_MIN-1 && car_present[green_dir]==0;
  - max-out: other_dem && cnt==GREEN_MAX-1.
  - With no other_dem, GREEN holds indefinitely regardless of timer.
- next_dir is latched on the GREEN->YELLOW transition. It is the first i scanning green_dir+1, green_dir+2, ... (mod NUM_DIR) with demand[i]=1. Approaches without demand are skipped. Demand arriving after the latch does not change next_dir.
- YELLOW: when cnt==YELLOW_T-1, go to ALL_RED.
- ALL_RED: when cnt==ALLRED_T-1, go to GREEN with green_dir<=next_dir. phase_start=1 for exactly that first GREEN cycle, otherwise 0.
- lights decode:
  - GREEN: approach green_dir=GREEN, others RED;
  - YELLOW: approach green_dir=YELLOW, others RED;
  - ALL_RED: all RED.
- Invariant: at most one approach is non-RED in any cycle.
- Phase durations are exact: GREEN >= GREEN_MIN cycles, YELLOW = YELLOW_T cycles, ALL_RED = ALLRED_T cycles.
- Out-of-range green_dir (non-power-of-two NUM_DIR) is unreachable; the FSM default recovers to reset state.

Test Plan:
(All with defaults NUM_DIR=4, GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=3, ALLRED_T=2.)
1. Idle: reset, then car_present=0 for 50 cycles -> lights=8'h01 throughout, green_dir=0, phase_start never asserted.
2. Gap-out with skip: after reset, car_present=4'b0100 for one cycle at cnt=0, car 0 absent -> demand[2] set next cycle; GREEN lasts 4 cycles; YELLOW on approach 0 for 3 cycles; lights=0 for 2 cycles; then green_dir=2, lights=8'h10, phase_start pulse. Approach 1 is skipped.
3. Max-out: car_present=4'b0011 held -> approach 0 GREEN exactly 10 cycles, YELLOW 3, ALL_RED 2, then green_dir=1. Approach 1 GREEN also maxes out at 10 cycles because demand[0] is set again.
4. Wrap-around: green_dir=3 with demand[1]=demand[0]=1 at exit -> next green_dir=0 (scan wraps 3->0 before reaching 1).
5. Reset mid-phase: assert reset on the second YELLOW cycle -> next cycle state GREEN, green_dir=0, demand=0, lights=8'h01, phase_start=0.
6. Self-demand only: car_present=4'b0001 held for 40 cycles -> approach 0 stays GREEN, demand stays 0, and the other approaches never leave RED.
